dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the core's data-memory port. Accepts one load or
//  store request from the Memory stage (address/storeData/byteEnable) and
//  answers after a fixed latency with loadData+loadDataValid or storeComplete.
//  Sits beside the Memory stage; holds a word-organised RAM with byte-lane writes.
// PARAMETERS
//  DEPTH_WORDS  4096          RAM depth in 32-bit words (power of two)
//  BASE_ADDR    32'h0000_0000 byte address of word 0
//  LATENCY      2             cycles from accept to response pulse (1..15)
// PORTS
//  clock          in   1   core clock, all state on rising edge
//  reset          in   1   asynchronous, active-low reset
//  address        in   32  byte address; bits [1:0] ignored (word access)
//  storeData      in   32  write data, lane-aligned by Memory stage
//  byteEnable     in   4   write lane enables, bit i -> storeData[8i+7:8i]
//  storeValid     in   1   store request, level, held until storeComplete
//  loadValid      in   1   load request, level, held until loadDataValid
//  loadData       out  32  full word read data, valid with loadDataValid
//  loadDataValid  out  1   one-cycle load response pulse
//  storeComplete  out  1   one-cycle store response pulse
//  busy           out  1   high in BUSY and RESP states
//  accessFault    out  1   one-cycle pulse with a response to out-of-range access
// BEHAVIOUR
//  - Reset (reset==0, async): state IDLE, counter 0, all outputs 0; an
//    in-flight request is dropped, no write occurs. RAM contents not cleared.
//  - FSM IDLE -> BUSY -> RESP -> IDLE.
//  - IDLE: if storeValid or loadValid, latch address/storeData/byteEnable/op,
//    load counter with LATENCY-1, go BUSY (LATENCY==1: go straight to RESP).
//  - Both valids high in same cycle: store is accepted, load ignored; the
//    requester re-presents the load after storeComplete.
//  - BUSY: decrement counter; at 0 go RESP. Inputs ignored.
//  - RESP (one cycle): pulse loadDataValid or storeComplete. Accept cycle T ->
//    pulse at T+LATENCY. Inputs ignored in RESP so a requester dropping valid
//    the cycle after the pulse is not re-accepted; next accept earliest T+LATENCY+1.
//  - Store: RAM write happens on the RESP edge, only lanes with byteEnable=1.
//    byteEnable==0 completes normally with no write.
//  - Load: RAM read in BUSY last cycle, registered into loadData; loadData
//    holds its last value outside the pulse.
//  - Range: index = (address-BASE_ADDR)>>2, 32-bit unsigned wrap on the
//    subtraction; index>=DEPTH_WORDS -> fault: response pulse still issued,
//    accessFault=1 same cycle, no write, loadData=32'h0.
//  - Store then load to same word: load sees stored data (write precedes accept).
// CONFIGURATION
//  DMEM_MMIO_EN defined: stores to word address MMIO_TOHOST (32'h1000_0000)
//    do not touch RAM and are not faults; extra outputs mmioData[31:0]
//    (byteEnable-merged over previous value, reset 0) and mmioValid (1-cycle
//    pulse coincident with storeComplete). Loads from it return mmioData.
//  Not defined: no MMIO ports; that address follows normal range/fault rules.
// STRUCTURE
//  Package pack: typedef enum logic [1:0] {DMEM_IDLE,DMEM_BUSY,DMEM_RESP}
//    dmemState_; typedef struct dmemRequest_ {address,storeData,byteEnable,isStore};
//    localparam MMIO_TOHOST.
//  One sub-module: dmem_byte_ram (DEPTH_WORDS x 32, 4 byte-lane write enables,
//    registered read) so FPGA block RAM inference is isolated.
// TESTING
//  1 Reset mid-BUSY: load accepted, reset low one cycle -> no loadDataValid
//    ever; outputs 0; busy 0.
//  2 Store 32'hDEADBEEF @0x40 byteEnable 4'b1111, LATENCY=2, accept T ->
//    storeComplete at T+2 only; load @0x40 -> loadData 32'hDEADBEEF.
//  3 Store 32'h0000AA00 @0x40 byteEnable 4'b0010 -> load @0x40 gives 32'hDEADAAEF.
//  4 storeValid and loadValid both high @0x44 -> only storeComplete; load
//    re-presented next IDLE -> loadDataValid with the stored word.
//  5 Load @BASE_ADDR+4*DEPTH_WORDS -> loadDataValid with accessFault=1,
//    loadData 0; store there -> storeComplete+accessFault, RAM unchanged.
//  6 DMEM_MMIO_EN: store 32'h41 to 32'h1000_0000 -> mmioValid pulse, mmioData 32'h41, RAM unchanged.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
//   dmemState_   : responder FSM states
//   dmemRequest_ : request captured at accept time
//   MMIO_TOHOST  : word address of the tohost MMIO register (DMEM_MMIO_EN builds)
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_RESP = 2'd2
  } dmemState_;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] storeData;
    logic [3:0]  byteEnable;
    logic        isStore;
  } dmemRequest_;

  localparam logic [31:0] MMIO_TOHOST = 32'h1000_0000;
  localparam int unsigned CNT_W       = 4;

  // Overlay enabled byte lanes of new_w onto old_w.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised RAM with byte-lane writes and a registered read port.
// Ports:
//   clock, reset   : clock and async active-low reset (read register only)
//   i_we, i_be     : write strobe and per-lane enables
//   i_addr         : word index shared by read and write
//   i_wdata        : write data
//   i_re           : load the read register
//   i_byp          : load i_byp_data instead of the array word
//   o_rdata        : registered read data, holds between reads
module dmem_byte_ram #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW          = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic          i_byp,
  input  logic [31:0]   i_byp_data,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Array write, no reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  // Read register; bypass carries fault zero / MMIO data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdata <= 32'h0;
    end else if (i_re) begin
      r_rdata <= i_byp ? i_byp_data : r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core data-memory port: accepts one load or
// store, answers LATENCY cycles later with a one-cycle response pulse.
// Optional feature macro: DMEM_MMIO_EN (tohost MMIO register at MMIO_TOHOST).
// Ports:
//   clock, reset            : clock, async active-low reset
//   address/storeData/byteEnable : request payload
//   storeValid/loadValid    : level requests, store wins when both set
//   loadData/loadDataValid  : read word and its pulse
//   storeComplete           : store response pulse
//   busy                    : high while BUSY or RESP
//   accessFault             : out-of-range flag alongside the response pulse
//   mmioData/mmioValid      : (DMEM_MMIO_EN only) tohost value and update pulse
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  input  logic [3:0]  byteEnable,
  input  logic        storeValid,
  input  logic        loadValid,
  output logic [31:0] loadData,
  output logic        loadDataValid,
  output logic        storeComplete,
  output logic        busy,
  output logic        accessFault
`ifdef DMEM_MMIO_EN
  ,
  output logic [31:0] mmioData,
  output logic        mmioValid
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  dmemState_          r_state;
  logic [CNT_W-1:0]   r_count;
  dmemRequest_        r_req;
  logic               r_load_valid;
  logic               r_store_complete;
  logic               r_busy;
  logic               r_fault;
  logic [31:0]        r_mmio_data;

  dmemRequest_        w_in_req;
  dmemRequest_        w_cur;
  logic               w_accept;
  logic               w_to_resp;
  logic [31:0]        w_word;
  logic               w_oob;
  logic               w_mmio;
  logic               w_fault;
  logic               w_ram_we;
  logic               w_ram_re;

  // Store has priority when both requests arrive together.
  assign w_in_req = '{address:    address,
                      storeData:  storeData,
                      byteEnable: byteEnable,
                      isStore:    storeValid};

  assign w_accept = (r_state == DMEM_IDLE) && (storeValid || loadValid);

  // With LATENCY==1 the RAM access happens on the accept edge itself, so the
  // live inputs are used instead of the latched request.
  assign w_cur     = (r_state == DMEM_IDLE) ? w_in_req : r_req;
  assign w_to_resp = (w_accept && (LATENCY == 1)) ||
                     ((r_state == DMEM_BUSY) && (r_count == CNT_W'(1)));

  // Unsigned wrap on the subtraction makes addresses below BASE_ADDR fault too.
  assign w_word = (w_cur.address - BASE_ADDR) >> 2;
  assign w_oob  = (w_word >= 32'(DEPTH_WORDS));

`ifdef DMEM_MMIO_EN
  assign w_mmio = (w_cur.address[31:2] == MMIO_TOHOST[31:2]);
`else
  assign w_mmio = 1'b0;
`endif

  assign w_fault  = w_oob && !w_mmio;
  assign w_ram_we = reset && w_to_resp && w_cur.isStore && !w_fault && !w_mmio;
  assign w_ram_re = w_to_resp && !w_cur.isStore;

  // Responder FSM with registered response pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state          <= DMEM_IDLE;
      r_count          <= '0;
      r_req            <= '0;
      r_load_valid     <= 1'b0;
      r_store_complete <= 1'b0;
      r_busy           <= 1'b0;
      r_fault          <= 1'b0;
    end else begin
      r_load_valid     <= 1'b0;
      r_store_complete <= 1'b0;
      r_fault          <= 1'b0;
      if (w_to_resp) begin
        r_load_valid     <= !w_cur.isStore;
        r_store_complete <= w_cur.isStore;
        r_fault          <= w_fault;
      end
      case (r_state)
        DMEM_IDLE: begin
          if (w_accept) begin
            r_req   <= w_in_req;
            r_count <= CNT_W'(LATENCY - 1);
            r_busy  <= 1'b1;
            r_state <= (LATENCY == 1) ? DMEM_RESP : DMEM_BUSY;
          end
        end
        DMEM_BUSY: begin
          r_count <= r_count - CNT_W'(1);
          if (r_count == CNT_W'(1)) r_state <= DMEM_RESP;
        end
        DMEM_RESP: begin
          r_busy  <= 1'b0;
          r_state <= DMEM_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= DMEM_IDLE;
        end
      endcase
    end
  end

`ifdef DMEM_MMIO_EN
  logic r_mmio_valid;

  // tohost register: byte-merged on store, pulse with storeComplete.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mmio_data  <= 32'h0;
      r_mmio_valid <= 1'b0;
    end else begin
      r_mmio_valid <= 1'b0;
      if (w_to_resp && w_cur.isStore && w_mmio) begin
        r_mmio_data  <= byte_merge(r_mmio_data, w_cur.storeData, w_cur.byteEnable);
        r_mmio_valid <= 1'b1;
      end
    end
  end

  assign mmioData  = r_mmio_data;
  assign mmioValid = r_mmio_valid;
`else
  assign r_mmio_data = 32'h0;
`endif

  dmem_byte_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clock      (clock),
    .reset      (reset),
    .i_we       (w_ram_we),
    .i_be       (w_cur.byteEnable),
    .i_addr     (w_word[AW-1:0]),
    .i_wdata    (w_cur.storeData),
    .i_re       (w_ram_re),
    .i_byp      (w_fault || w_mmio),
    .i_byp_data (w_mmio ? r_mmio_data : 32'h0),
    .o_rdata    (loadData)
  );

  assign loadDataValid = r_load_valid;
  assign storeComplete = r_store_complete;
  assign busy          = r_busy;
  assign accessFault   = r_fault;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus randomized
// load/store traffic checked against a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 4096;
  localparam int unsigned LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clock;
  logic        reset;
  logic [31:0] address;
  logic [31:0] storeData;
  logic [3:0]  byteEnable;
  logic        storeValid;
  logic        loadValid;
  logic [31:0] loadData;
  logic        loadDataValid;
  logic        storeComplete;
  logic        busy;
  logic        accessFault;
`ifdef DMEM_MMIO_EN
  logic [31:0] mmioData;
  logic        mmioValid;
`endif

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .LATENCY     (LAT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .storeData     (storeData),
    .byteEnable    (byteEnable),
    .storeValid    (storeValid),
    .loadValid     (loadValid),
    .loadData      (loadData),
    .loadDataValid (loadDataValid),
    .storeComplete (storeComplete),
    .busy          (busy),
    .accessFault   (accessFault)
`ifdef DMEM_MMIO_EN
    ,
    .mmioData      (mmioData),
    .mmioValid     (mmioValid)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: sparse word store keyed by word index, plus tohost.
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] ref_mmio = 32'h0;

  function automatic bit is_mmio(input logic [31:0] addr);
`ifdef DMEM_MMIO_EN
    return (addr >> 2) == (32'h1000_0000 >> 2);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int unsigned word_of(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return int'(off / 4);
  endfunction

  function automatic bit is_fault(input logic [31:0] addr);
    return (word_of(addr) >= DEPTH) && !is_mmio(addr);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] addr);
    if (is_mmio(addr)) return ref_mmio;
    if (is_fault(addr)) return 32'h0;
    if (ref_mem.exists(word_of(addr))) return ref_mem[word_of(addr)];
    return 32'h0;
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  // One request: present it, wait for the response, check timing and payload.
  task automatic do_txn(input string tag, input bit st, input bit both,
                        input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    bit          exp_store;
    bit          exp_fault;
    logic [31:0] exp_data;
    int          cyc;
    bit          busy_ok;
    exp_store = st || both;
    exp_fault = is_fault(addr);
    exp_data  = ref_read(addr);
    @(negedge clock);
    address    = addr;
    storeData  = data;
    byteEnable = be;
    storeValid = exp_store;
    loadValid  = !st || both;
    cyc        = 0;
    busy_ok    = 1'b1;
    do begin
      @(negedge clock);
      cyc++;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end while (!(loadDataValid || storeComplete) && cyc < 20);
    check({tag, ".latency"}, 32'(cyc), 32'(LAT));
    check({tag, ".busy"}, 32'(busy_ok), 32'd1);
    check({tag, ".kind"}, 32'({storeComplete, loadDataValid}), exp_store ? 32'd2 : 32'd1);
    check({tag, ".fault"}, 32'(accessFault), 32'(exp_fault));
    if (!exp_store) check({tag, ".data"}, loadData, exp_data);
    storeValid = 1'b0;
    loadValid  = 1'b0;
`ifdef DMEM_MMIO_EN
    check({tag, ".mmiov"}, 32'(mmioValid), 32'(exp_store && is_mmio(addr)));
`endif
    @(negedge clock);
    check({tag, ".idle"}, 32'({busy, storeComplete, loadDataValid, accessFault}), 32'd0);
    if (!exp_store) check({tag, ".hold"}, loadData, exp_data);
    if (exp_store) begin
      if (is_mmio(addr)) ref_mmio = lanes(ref_mmio, data, be);
      else if (!exp_fault) ref_mem[word_of(addr)] = lanes(ref_read(addr), data, be);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [31:0] a;
    reset      = 1'b0;
    address    = 32'h0;
    storeData  = 32'h0;
    byteEnable = 4'h0;
    storeValid = 1'b0;
    loadValid  = 1'b0;
    repeat (3) @(negedge clock);
    check("reset.ctrl", 32'({busy, loadDataValid, storeComplete, accessFault}), 32'd0);
    check("reset.data", loadData, 32'h0);
    reset = 1'b1;

    // Reset while a load is in BUSY: it must be dropped.
    @(negedge clock);
    address   = 32'h40;
    loadValid = 1'b1;
    @(negedge clock);
    check("t1.accepted", 32'(busy), 32'd1);
    reset     = 1'b0;
    loadValid = 1'b0;
    #1;
    check("t1.rst_ctrl", 32'({busy, loadDataValid, storeComplete, accessFault}), 32'd0);
    check("t1.rst_data", loadData, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    seen  = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (loadDataValid || busy) seen = 1'b1;
    end
    check("t1.no_resp", 32'(seen), 32'd0);

    // Full-word store, then partial-lane overwrite.
    do_txn("t2.st", 1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF, 4'b1111);
    do_txn("t2.ld", 1'b0, 1'b0, 32'h40, 32'h0, 4'h0);
    check("t2.word", loadData, 32'hDEAD_BEEF);
    do_txn("t3.st", 1'b1, 1'b0, 32'h40, 32'h0000_AA00, 4'b0010);
    do_txn("t3.ld", 1'b0, 1'b0, 32'h40, 32'h0, 4'h0);
    check("t3.word", loadData, 32'hDEAD_AAEF);

    // Simultaneous valids: store wins, load re-presented afterwards.
    do_txn("t4.both", 1'b0, 1'b1, 32'h44, 32'h1234_5678, 4'b1111);
    do_txn("t4.ld", 1'b0, 1'b0, 32'h44, 32'h0, 4'h0);
    check("t4.word", loadData, 32'h1234_5678);

    // Out-of-range: fault on load and store, word 0 must stay intact.
    do_txn("t5.w0", 1'b1, 1'b0, BASE, 32'hA5A5_5A5A, 4'b1111);
    do_txn("t5.ld", 1'b0, 1'b0, BASE + 4 * DEPTH, 32'h0, 4'h0);
    do_txn("t5.st", 1'b1, 1'b0, BASE + 4 * DEPTH, 32'hFFFF_FFFF, 4'b1111);
    do_txn("t5.chk", 1'b0, 1'b0, BASE, 32'h0, 4'h0);
    check("t5.word0", loadData, 32'hA5A5_5A5A);
    do_txn("t5.neg", 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0);

`ifdef DMEM_MMIO_EN
    do_txn("t6.st", 1'b1, 1'b0, 32'h1000_0000, 32'h41, 4'b1111);
    check("t6.mmio", mmioData, 32'h41);
    do_txn("t6.ld", 1'b0, 1'b0, 32'h1000_0000, 32'h0, 4'h0);
    do_txn("t6.ram", 1'b0, 1'b0, BASE, 32'h0, 4'h0);
`endif

    // Randomized traffic over a 16-word pool plus occasional faults.
    for (int i = 0; i < 16; i++)
      do_txn("init", 1'b1, 1'b0, 32'h100 + 32'(4 * i), $urandom, 4'b1111);
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0)
        a = 32'h4000 + ($urandom & 32'h0FFF_FFFC);
      else
        a = 32'h100 + 32'(4 * $urandom_range(0, 15));
      a[1:0] = 2'($urandom_range(0, 3));
      do_txn("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
             a, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
